// File: rtl/sb_ser_pkg.sv
// Shared types and default sizing for the sideband serializer.
package sb_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } sb_state_e;

    localparam int SB_PKT_WIDTH  = 64;
    localparam int SB_GAP_CYCLES = 32;

endpackage

// File: rtl/sb_serializer_gap_timer.sv
// Loadable down-counter; done is high once the count has drained to zero.
module sb_gap_timer #(
    parameter int GAP_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    output logic             done
);

    logic [GAP_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sb_serializer.sv
// Sideband TX serializer, LSB first, with forwarded-clock enable.
// Optional post-packet idle gap is compiled in with SB_SER_IDLE_GAP_EN.
module sb_serializer
    import sb_ser_pkg::*;
#(
    parameter int WIDTH   = SB_PKT_WIDTH,
    parameter int WIDTH_W = 6,
    parameter int GAP     = SB_GAP_CYCLES,
    parameter int GAP_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_data_valid,
    output logic             in_data_ready,
    output logic             out_data,
    output logic             out_clk_en,
    output logic             busy
);

    sb_state_e          state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH_W-1:0] cnt_q;
    logic               out_data_q;
    logic               clk_en_q;
    logic               lastBit;
    logic               accept;

    if ((1 << WIDTH_W) < WIDTH) begin : gWidthCheck
        $error("sb_serializer: WIDTH_W too small for WIDTH");
    end
    if ((1 << GAP_W) <= GAP) begin : gGapCheck
        $error("sb_serializer: GAP_W too small for GAP");
    end

    assign lastBit = (state_q == ST_SHIFT) && (cnt_q == WIDTH_W'(WIDTH - 1));
    assign accept  = in_data_valid && in_data_ready;

`ifdef SB_SER_IDLE_GAP_EN
    logic gapDone;

    assign in_data_ready = !rst && (state_q == ST_IDLE);

    // Loaded with GAP-1 while the last bit launches, so the GAP state lasts GAP cycles.
    sb_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (lastBit),
        .load_val (GAP_W'(GAP - 1)),
        .done     (gapDone)
    );
`else
    assign in_data_ready = !rst && ((state_q == ST_IDLE) || lastBit);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            out_data_q <= 1'b0;
            clk_en_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_data_q <= 1'b0;
                    clk_en_q   <= 1'b0;
                    if (accept) begin
                        shift_q <= in_data;
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    out_data_q <= shift_q[0];
                    clk_en_q   <= 1'b1;
                    shift_q    <= {1'b0, shift_q[WIDTH-1:1]};
                    cnt_q      <= cnt_q + 1'b1;
                    if (lastBit) begin
                        cnt_q <= '0;
`ifdef SB_SER_IDLE_GAP_EN
                        state_q <= ST_GAP;
`else
                        // A packet taken on the last bit streams out with no bubble.
                        if (accept) begin
                            shift_q <= in_data;
                        end else begin
                            state_q <= ST_IDLE;
                        end
`endif
                    end
                end
`ifdef SB_SER_IDLE_GAP_EN
                ST_GAP: begin
                    out_data_q <= 1'b0;
                    clk_en_q   <= 1'b0;
                    if (gapDone) begin
                        state_q <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    out_data_q <= 1'b0;
                    clk_en_q   <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data   = out_data_q;
    assign out_clk_en = clk_en_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sb_serializer.sv
// Directed self-checking bench for sb_serializer (default or SB_SER_IDLE_GAP_EN build).
module tb_sb_serializer;

    localparam int WIDTH = 64;
    localparam int GAP   = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] inData;
    logic             inDataValid;
    logic             inDataReady;
    logic             outData;
    logic             outClkEn;
    logic             busy;

    int checkCount = 0;
    int errorCount = 0;

    logic             monClear;
    logic [WIDTH-1:0] rxData;
    logic [WIDTH-1:0] rxFirst;
    int               rxCount;
    int               clkEnCount;
    int               busyCount;
    int               run;
    int               maxRun;
    int               lowRun;
    int               lastLowRun;
    int               riseCount;
    int               riseTime [2];
    int               cycle;
    logic             prevEn;

    sb_serializer #(
        .WIDTH   (WIDTH),
        .WIDTH_W (6),
        .GAP     (GAP),
        .GAP_W   (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (inData),
        .in_data_valid (inDataValid),
        .in_data_ready (inDataReady),
        .out_data      (outData),
        .out_clk_en    (outClkEn),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Receiver model: samples the lane on the falling edge, bit 0 first, plus lane statistics.
    always @(negedge clk) begin
        if (monClear) begin
            rxData = '0; rxFirst = '0; rxCount = 0; clkEnCount = 0; busyCount = 0;
            run = 0; maxRun = 0; lowRun = 0; lastLowRun = 0; riseCount = 0;
            riseTime[0] = 0; riseTime[1] = 0; cycle = 0; prevEn = 1'b0;
        end else begin
            cycle++;
            if (outClkEn) begin
                rxData = {outData, rxData[WIDTH-1:1]};
                rxCount++;
                if (rxCount == WIDTH) rxFirst = rxData;
                clkEnCount++;
                run++;
                if (run > maxRun) maxRun = run;
                if (!prevEn) begin
                    if (riseCount < 2) riseTime[riseCount] = cycle;
                    riseCount++;
                    lastLowRun = lowRun;
                end
                lowRun = 0;
            end else begin
                run = 0;
                lowRun++;
            end
            if (busy) busyCount++;
            prevEn = outClkEn;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data);
        inDataValid = valid;
        inData      = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearMonitor();
        monClear = 1'b1;
        @(negedge clk);
        #1;
        monClear = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!(inDataReady && !busy) && n < 300) begin
            tick();
            n++;
        end
        checkOutput("idle_timeout", 64'(n < 300), 64'd1);
    endtask

    task automatic expectBits(input string tag, input logic [WIDTH-1:0] pkt);
        for (int k = 0; k < WIDTH; k++) begin
            tick();
            checkOutput({tag, "_bit"}, 64'(outData), 64'(pkt[k]));
            checkOutput({tag, "_clken"}, 64'(outClkEn), 64'd1);
        end
    endtask

    localparam logic [WIDTH-1:0] PKT1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [WIDTH-1:0] PKT2 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [WIDTH-1:0] PKTA = 64'hA5A5_0F0F_1234_8001;
    localparam logic [WIDTH-1:0] PKTB = 64'h8000_0000_FFFF_0003;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        monClear = 1'b1;
        rst      = 1'b1;
        applyStimulus(1'b1, PKT1);

        // Reset held with valid high: nothing may be accepted.
        repeat (3) tick();
        checkOutput("rst_ready", 64'(inDataReady), 64'd0);
        checkOutput("rst_out_data", 64'(outData), 64'd0);
        checkOutput("rst_clk_en", 64'(outClkEn), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        clearMonitor();
        rst = 1'b0;
        #1;
        checkOutput("rel_ready", 64'(inDataReady), 64'd1);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("accept_busy", 64'(busy), 64'd1);
        checkOutput("accept_lane_quiet", 64'(outData), 64'd0);
        expectBits("p1", PKT1);
        tick();
        checkOutput("p1_clken_end", 64'(outClkEn), 64'd0);
        checkOutput("p1_rx", rxData, PKT1);
        checkOutput("p1_rx_count", 64'(rxCount), 64'd64);
        checkOutput("p1_clken_cycles", 64'(clkEnCount), 64'd64);
        waitIdle();

        // New data offered mid-packet must not disturb the packet in flight.
        clearMonitor();
        applyStimulus(1'b1, PKT2);
        tick();
        applyStimulus(1'b0, '0);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == 5)  applyStimulus(1'b1, ~PKT2);
            if (i == 20) checkOutput("p2_ready_mid", 64'(inDataReady), 64'd0);
            if (i == 40) applyStimulus(1'b0, 64'h1111_2222_3333_4444);
            tick();
        end
        tick();
        checkOutput("p2_rx", rxData, PKT2);
        checkOutput("p2_rx_count", 64'(rxCount), 64'd64);
        waitIdle();

        // Valid held across two packets.
        clearMonitor();
        applyStimulus(1'b1, PKTA);
        tick();
        applyStimulus(1'b1, PKTB);
`ifdef SB_SER_IDLE_GAP_EN
        begin
            int n;
            n = 0;
            while (riseCount < 2 && n < 300) begin
                tick();
                n++;
            end
            checkOutput("gap_rise_timeout", 64'(n < 300), 64'd1);
        end
        applyStimulus(1'b0, '0);
        checkOutput("gap_period", 64'(riseTime[1] - riseTime[0]), 64'(WIDTH + GAP + 1));
        checkOutput("gap_low_min", 64'(lastLowRun >= GAP), 64'd1);
        repeat (WIDTH) tick();
        waitIdle();
        checkOutput("gap_rx_a", rxFirst, PKTA);
        checkOutput("gap_rx_b", rxData, PKTB);
`else
        for (int i = 1; i < WIDTH; i++) begin
            tick();
            if (i == 10) checkOutput("b2b_ready_mid", 64'(inDataReady), 64'd0);
        end
        checkOutput("b2b_ready_last", 64'(inDataReady), 64'd1);
        tick();
        applyStimulus(1'b0, '0);
        expectBits("b2b_b", PKTB);
        tick();
        checkOutput("b2b_max_run", 64'(maxRun), 64'd128);
        checkOutput("b2b_clken_cycles", 64'(clkEnCount), 64'd128);
        checkOutput("b2b_busy_cycles", 64'(busyCount), 64'd128);
        checkOutput("b2b_rx_a", rxFirst, PKTA);
        checkOutput("b2b_rx_b", rxData, PKTB);
        waitIdle();
`endif

        // Reset pulsed while bit 20 of an all-ones packet is on the lane.
        clearMonitor();
        applyStimulus(1'b1, '1);
        tick();
        applyStimulus(1'b0, '0);
        repeat (21) tick();
        checkOutput("mid_bit20", 64'(outData), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_data", 64'(outData), 64'd0);
        checkOutput("mid_rst_clken", 64'(outClkEn), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mid_rel_ready", 64'(inDataReady), 64'd1);
        checkOutput("mid_rel_busy", 64'(busy), 64'd0);
        clearMonitor();
        applyStimulus(1'b1, 64'h1);
        tick();
        applyStimulus(1'b0, '0);
        expectBits("p1h", 64'h1);
        tick();
        checkOutput("p1h_rx", rxData, 64'h1);
        checkOutput("p1h_clken_cycles", 64'(clkEnCount), 64'd64);
        checkOutput("p1h_busy_cycles", 64'(busyCount), 64'd64);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
